// File: rtl/fofb_plane_scheduler.sv
// fofb_plane_scheduler: sequences X then Y plane RAM reads into a stream whose
// qualifiers follow the RAM read latency, with trigger sync and overrun tracking.
module fofb_plane_scheduler #(
    parameter int AW   = 9,
    parameter int PIPE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] len_x,
    input  logic [AW-1:0] len_y,
    input  logic          m_tready,
    input  logic          clr_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_en,
    output logic          ram_plane,
    output logic          m_tvalid,
    output logic          m_tlast,
    output logic          m_tuser,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [15:0]   overrun_cnt
);
    typedef enum logic [2:0] {IDLE, RUN_X, GAP, RUN_Y, DRAIN} state_t;
    state_t state, state_n;
    logic [2:0] sync;
    logic [AW-1:0] lx, ly, cur_len;
    logic [PIPE-1:0] pv, pl, pu;
    logic trig, advance, is_last, drained;
    assign trig      = sync[1] & ~sync[2];
    assign advance   = ~(m_tvalid & ~m_tready);
    assign ram_en    = (state == RUN_X || state == RUN_Y) & advance;
    assign cur_len   = ram_plane ? ly : lx;
    assign is_last   = ram_addr == cur_len - AW'(1);
    // only the output stage may still hold a beat, and it leaves this cycle
    assign drained   = advance && (pv >> 1) == '0;
    assign m_tvalid  = pv[0];
    assign m_tlast   = pl[0];
    assign m_tuser   = pu[0];
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trig) state_n = len_x != '0 ? RUN_X : len_y != '0 ? RUN_Y : DRAIN;
            RUN_X:   if (advance && is_last) state_n = ly != '0 ? GAP : DRAIN;
            GAP:     state_n = RUN_Y;
            RUN_Y:   if (advance && is_last) state_n = DRAIN;
            DRAIN:   if (drained) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sync        <= '0;
            lx          <= '0;
            ly          <= '0;
            ram_addr    <= '0;
            ram_plane   <= 1'b0;
            pv          <= '0;
            pl          <= '0;
            pu          <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            sync  <= {sync[1:0], start};
            state <= state_n;
            done  <= state == DRAIN && drained;
            if (state == IDLE && trig) begin
                lx        <= len_x;
                ly        <= len_y;
                ram_plane <= len_x == '0;
                ram_addr  <= '0;
            end else if (state == GAP) begin
                ram_plane <= 1'b1;
                ram_addr  <= '0;
            end else if (state == DRAIN && drained) begin
                ram_plane <= 1'b0;
            end else if (ram_en) begin
                ram_addr <= is_last ? '0 : ram_addr + AW'(1);
            end
            // stage PIPE-1 takes the issued read, stage 0 faces the stream
            if (advance) begin
                for (int i = 0; i < PIPE - 1; i++) begin
                    pv[i] <= pv[i+1];
                    pl[i] <= pl[i+1];
                    pu[i] <= pu[i+1];
                end
                pv[PIPE-1] <= ram_en;
                pl[PIPE-1] <= ram_en & is_last;
                pu[PIPE-1] <= ram_en & ram_plane;
            end
            if (clr_err) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end else if (trig && state != IDLE) begin
                overrun <= 1'b1;
                if (overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/fofb_plane_scheduler.md
FOFB_PLANE_SCHEDULER -- requirements
Module: fofb_plane_scheduler

Interface
REQ-001 Parameter AW, default 9: width of the RAM address and length fields.
REQ-002 Parameter PIPE, default 2: read latency of the coefficient/BPM RAM in clk cycles, range 1..4.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  calculation trigger, may be asynchronous to clk; level, rising edge significant.
REQ-006 len_x, len_y  input  AW each  word count for X and Y plane; 0 = plane skipped.
REQ-007 m_tready  input  1  downstream accepts the current beat.
REQ-008 clr_err  input  1  clears overrun and overrun_cnt.
REQ-009 ram_addr  output  AW  RAM read address.
REQ-010 ram_en  output  1  RAM read/clock enable; the RAM holds its output when low.
REQ-011 ram_plane  output  1  plane select for the RAM, 0=X, 1=Y.
REQ-012 m_tvalid, m_tlast, m_tuser  output  1 each  stream qualifiers aligned to RAM data; m_tuser = plane.
REQ-013 busy  output  1  high from accepted trigger until done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 overrun  output  1  sticky flag: trigger arrived while busy.
REQ-016 overrun_cnt  output  16  saturating count of such triggers.

Function
REQ-017 start SHALL pass through two synchronizer flops plus one edge-detect flop; a trigger is a 0->1 transition of the second flop.
REQ-018 State machine states: IDLE, RUN_X, GAP, RUN_Y, DRAIN.
REQ-019 On a trigger in IDLE: latch len_x/len_y, assert busy, and enter RUN_X (len_x != 0), else RUN_Y (len_y != 0), else DRAIN.
REQ-020 In RUN_X/RUN_Y: ram_en = advance, where advance = NOT (m_tvalid AND NOT m_tready); ram_addr starts at 0 and increments by 1 per advance.
REQ-021 Leaving RUN_X after the advance at address len_x-1: go to GAP if len_y != 0, else DRAIN; leaving RUN_Y after address len_y-1: go to DRAIN.
REQ-022 GAP lasts exactly one cycle with ram_en=0; ram_addr returns to 0 and ram_plane becomes 1.
REQ-023 A PIPE-deep valid/last/plane shift register, enabled by advance, SHALL carry each issued address; m_tvalid/m_tlast/m_tuser are its final stage.
REQ-024 First m_tvalid SHALL appear exactly PIPE cycles after the first ram_en when m_tready is held 1.
REQ-025 m_tlast SHALL be high only on the final word of each non-skipped plane.
REQ-026 Under backpressure, m_tvalid/m_tlast/m_tuser and ram_addr SHALL hold unchanged; no beat is lost or duplicated.
REQ-027 DRAIN: wait until the pipeline is empty and the last beat is accepted; then pulse done for one cycle, drop busy, and return to IDLE in that same cycle.
REQ-028 Both lengths 0: no beats; done SHALL pulse the cycle after DRAIN is entered.
REQ-029 A trigger while busy SHALL be ignored, set overrun, and increment overrun_cnt, saturating at 0xFFFF.
REQ-030 clr_err coincident with an overrun trigger: clear wins, and the result is overrun=0, cnt=0.
REQ-031 len_x/len_y changes during a run SHALL have no effect until the next trigger.

Reset
REQ-032 reset SHALL force IDLE, clear the synchronizer and pipeline, and drive ram_addr=0, ram_en=0, ram_plane=0, m_tvalid=m_tlast=m_tuser=0, busy=0, done=0, overrun=0, overrun_cnt=0.
REQ-033 reset mid-run SHALL abort with no done pulse; a trigger SHALL be accepted normally after reset releases.

Verification
REQ-034 len_x=4, len_y=3, tready=1, start pulse -> beats X addr 0..3 (tlast on 3), one-cycle gap, Y addr 0..2 (tlast on 2), m_tvalid PIPE cycles after ram_en, single done pulse.
REQ-035 len_x=359, len_y=359, tready random 50% -> 718 beats in address order, 2 tlast, no duplicates or drops, done after the final handshake.
REQ-036 len_x=0, len_y=5 -> only Y beats 0..4 with m_tuser=1; len_x=len_y=0 -> no m_tvalid, done pulses once.
REQ-037 Three extra start pulses during a run -> overrun=1, overrun_cnt=3, stream unaffected; clr_err -> both 0.
REQ-038 reset asserted at X address 10 -> all outputs at reset values the next cycle, no done; a new start runs a full sequence.
REQ-039 Hold start high -> exactly one trigger; start pulse of 1 clk -> exactly one trigger.
